opb_register_bank_ppc2simulink: RTL and testbench
=================================================

Name: opb_register_bank_ppc2simulink

Overview:
Parametrised successor to the single-register software-to-fabric control register. It is an OPB slave holding C_NUM_REGS 32-bit control words (count limits, thresholds, mode bits) for the fabric. Writes land in shadow registers. A commit write transfers all shadows to the fabric outputs in the same cycle, so multi-word settings change atomically. Everything runs on the OPB clock; the user-side logic samples the outputs there or re-synchronises them itself.

Parameters:
C_BASEADDR, 32'h0110C400, first byte address of the bank.
C_HIGHADDR, 32'h0110C4FF, last byte address decoded; must cover 4*(C_NUM_REGS+1) bytes.
C_NUM_REGS, 4, number of data registers (1..32).
C_INIT, 32'h00000000, reset value of every shadow and output word.
C_AUTO_COMMIT, 0, 1 = every data write also updates its output word directly (legacy single-register behaviour).

Ports:
OPB_Clk  in  1  sole clock.
OPB_Rst  in  1  synchronous, active-high reset.
OPB_ABus  in  [0:31]  address.
OPB_BE  in  [0:3]  byte enables; BE[0] covers DBus[0:7].
OPB_DBus  in  [0:31]  write data.
OPB_RNW  in  1  1 = read, 0 = write.
OPB_select  in  1  transfer request.
OPB_seqAddr  in  1  ignored.
Sl_DBus  out  [0:31]  read data.
Sl_xferAck  out  1  transfer acknowledge.
Sl_errAck  out  1  tied 0.
Sl_retry  out  1  tied 0.
Sl_toutSup  out  1  tied 0.
user_data_out  out  [32*C_NUM_REGS-1:0]  committed words; word i is at bits [32i+31:32i]; OPB bit 0 maps to user bit 31.
user_update  out  1  one-cycle pulse whenever user_data_out changes.
user_dirty  out  1  shadows differ from committed outputs.

Behaviour:
- Clock and reset: one clock, OPB_Clk. Reset OPB_Rst is synchronous and active-high.
- Reset values: all shadows and outputs = C_INIT; Sl_DBus=0; Sl_xferAck=0; user_update=0; user_dirty=0; FSM=IDLE.
- Address map: data reg i at C_BASEADDR+4i. CTRL at C_BASEADDR+4*C_NUM_REGS. Other in-range offsets: ack with read data 0, writes ignored. Out-of-range addresses: no response at all.
- Handshake FSM:
  - IDLE: on select && in-range, latch address/RNW/data/BE, then go to ACK.
  - ACK (1 cycle): Sl_xferAck=1; Sl_DBus valid; write takes effect at this edge. Then go to HOLD.
  - HOLD: wait for select=0, then go to IDLE. This guarantees one ack per transfer.
  - Latency: xferAck is asserted exactly 1 cycle after select is first sampled.
- Sl_DBus is 0 in every cycle except ACK.
- Data write: each byte lane with BE set updates the shadow; other lanes are kept. Sets dirty.
- CTRL write with DBus[31]=1 (commit):
  - Copies all shadows to outputs at the ACK edge.
  - user_update pulses in the following cycle.
  - Clears dirty.
- CTRL write with DBus[30]=1 (revert): copies outputs back into shadows and clears dirty.
- Both commit and revert bits set: commit wins.
- CTRL read returns {30'b0, C_AUTO_COMMIT, dirty} in OPB bits [0:31]; dirty is at bit 31.
- C_AUTO_COMMIT=1: a data write updates shadow and output together and pulses user_update; dirty stays 0; commit is a harmless no-op.
- Reset while in ACK or HOLD: FSM returns to IDLE, no ack is issued, and the pending write is discarded.

Optional Feature:
OPB_REGBANK_READBACK_EN:
- Defined: a data-register read returns the shadow word. If C_NUM_REGS+1 <= 64, offset 4*(C_NUM_REGS+1) returns a 32-bit commit counter that increments per commit and wraps at 2^32.
- Undefined: data-register reads return 0; the counter is not built.
- CTRL read and the handshake are unchanged either way.

Test Plan:
- Reset -> user_data_out all words = C_INIT, user_dirty=0, Sl_xferAck=0 and Sl_DBus=0 after reset release.
- Write 0xDEADBEEF to reg 1, all BE set -> xferAck exactly 1 cycle after select; output word 1 unchanged; user_dirty=1; CTRL read = 0x00000001.
- Write BE=0011 with data 0x12345678 to reg 0 (shadow 0xAABBCCDD), then commit -> word 0 = 0xAABB5678; user_update one pulse; dirty=0.
- Write reg 2 = 5, then CTRL = 0x00000002 (revert) -> shadow 2 = C_INIT, outputs unchanged, no user_update; with READBACK_EN, read of reg 2 returns C_INIT.
- Hold select high for 5 cycles -> exactly one xferAck; reset asserted in the ACK cycle -> no ack, no register change.
- C_AUTO_COMMIT=1: write reg 3 = 7 -> word 3 = 7 one cycle after ACK, user_update pulses, CTRL read = 0x00000002.

Source files
------------

// File: rtl/opb_register_bank_ppc2simulink.sv
// opb_register_bank_ppc2simulink: OPB bank of shadowed control words with atomic commit; OPB_REGBANK_READBACK_EN enables shadow/commit-counter readback
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR    = 32'h0110C400,
  parameter logic [31:0] C_HIGHADDR    = 32'h0110C4FF,
  parameter int          C_NUM_REGS    = 4,
  parameter logic [31:0] C_INIT        = 32'h00000000,
  parameter bit          C_AUTO_COMMIT = 1'b0
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  input  logic [0:31]             OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:31]             OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:31]             Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  output logic [32*C_NUM_REGS-1:0] user_data_out,
  output logic                    user_update,
  output logic                    user_dirty
);
  localparam int N = C_NUM_REGS;
  localparam bit HAS_CNT = (N + 1 <= 64);
  typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;
  state_t      state_q;
  logic [31:0] shadow_q [N];
  logic [31:0] out_q [N];
  logic [31:0] idx_q, data_q, dbus_q, rd, wmask;
  logic [3:0]  be_q;
  logic        rnw_q, ack_q, upd_q, dirty_q;
`ifdef OPB_REGBANK_READBACK_EN
  logic [31:0] cnt_q;
`endif
  wire  [31:0] abus = OPB_ABus;
  wire  [31:0] idx = (abus - C_BASEADDR) >> 2;
  wire         in_range = (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
  assign wmask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
  assign Sl_DBus = dbus_q;
  assign Sl_xferAck = ack_q;
  assign Sl_errAck = 1'b0;
  assign Sl_retry = 1'b0;
  assign Sl_toutSup = OPB_seqAddr & 1'b0;
  assign user_update = upd_q;
  assign user_dirty = dirty_q;
  for (genvar i = 0; i < N; i++) begin : g_out
    assign user_data_out[32*i +: 32] = out_q[i];
  end
  // read data for the addressed word, captured when the transfer is accepted
  always_comb begin
    rd = (idx == 32'(N)) ? {30'b0, C_AUTO_COMMIT, dirty_q} : 32'b0;
`ifdef OPB_REGBANK_READBACK_EN
    for (int i = 0; i < N; i++) rd = (idx == 32'(i)) ? shadow_q[i] : rd;
    rd = (HAS_CNT && idx == 32'(N + 1)) ? cnt_q : rd;
`endif
  end
  // handshake FSM; writes, commits and reverts take effect at the edge ending ACK
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_q <= IDLE;
      ack_q <= 1'b0;
      dbus_q <= 32'b0;
      upd_q <= 1'b0;
      dirty_q <= 1'b0;
      idx_q <= 32'b0;
      data_q <= 32'b0;
      be_q <= 4'b0;
      rnw_q <= 1'b1;
`ifdef OPB_REGBANK_READBACK_EN
      cnt_q <= 32'b0;
`endif
      for (int i = 0; i < N; i++) begin
        shadow_q[i] <= C_INIT;
        out_q[i] <= C_INIT;
      end
    end else begin
      ack_q <= 1'b0;
      dbus_q <= 32'b0;
      upd_q <= 1'b0;
      case (state_q)
        IDLE: if (OPB_select && in_range) begin
          state_q <= ACK;
          ack_q <= 1'b1;
          dbus_q <= OPB_RNW ? rd : 32'b0;
          idx_q <= idx;
          rnw_q <= OPB_RNW;
          data_q <= OPB_DBus;
          be_q <= OPB_BE;
        end
        ACK: begin
          state_q <= HOLD;
          if (!rnw_q) begin
            for (int i = 0; i < N; i++) begin
              if (idx_q == 32'(i)) begin
                shadow_q[i] <= (shadow_q[i] & ~wmask) | (data_q & wmask);
                if (C_AUTO_COMMIT) begin
                  out_q[i] <= (shadow_q[i] & ~wmask) | (data_q & wmask);
                  upd_q <= 1'b1;
                end else dirty_q <= 1'b1;
              end
            end
            if (idx_q == 32'(N)) begin
              if (data_q[0]) begin
                if (!C_AUTO_COMMIT) begin
                  for (int i = 0; i < N; i++) out_q[i] <= shadow_q[i];
                  upd_q <= 1'b1;
                  dirty_q <= 1'b0;
`ifdef OPB_REGBANK_READBACK_EN
                  cnt_q <= cnt_q + 32'd1;
`endif
                end
              end else if (data_q[1]) begin
                for (int i = 0; i < N; i++) shadow_q[i] <= out_q[i];
                dirty_q <= 1'b0;
              end
            end
          end
        end
        HOLD: state_q <= OPB_select ? HOLD : IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// tb_opb_register_bank_ppc2simulink: directed checks of handshake, byte lanes, commit, revert, reset and auto-commit
module tb_opb_register_bank_ppc2simulink;
  localparam logic [31:0] BASE = 32'h0110C400;
  localparam logic [31:0] INIT_A = 32'h5A5A0000;
  logic clk = 1'b0, rst = 1'b1;
  logic [0:31] abus = '0, dbus = '0;
  logic [0:3]  be = '0;
  logic        rnw = 1'b1, sel_a = 1'b0, sel_b = 1'b0;
  logic [0:31] sl_dbus_a, sl_dbus_b;
  logic        ack_a, ack_b, err_a, err_b, retry_a, retry_b, tout_a, tout_b;
  logic        upd_a, upd_b, dirty_a, dirty_b;
  logic [127:0] uda_a, uda_b;
  int checks = 0, errors = 0;
  logic [31:0] rdata;
  int lat, acks;
  always #5 clk = ~clk;
  opb_register_bank_ppc2simulink #(.C_INIT(INIT_A)) u_a (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel_a), .OPB_seqAddr(1'b0), .Sl_DBus(sl_dbus_a),
    .Sl_xferAck(ack_a), .Sl_errAck(err_a), .Sl_retry(retry_a), .Sl_toutSup(tout_a),
    .user_data_out(uda_a), .user_update(upd_a), .user_dirty(dirty_a));
  opb_register_bank_ppc2simulink #(.C_AUTO_COMMIT(1'b1)) u_b (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel_b), .OPB_seqAddr(1'b0), .Sl_DBus(sl_dbus_b),
    .Sl_xferAck(ack_b), .Sl_errAck(err_b), .Sl_retry(retry_b), .Sl_toutSup(tout_b),
    .user_data_out(uda_b), .user_update(upd_b), .user_dirty(dirty_b));
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic xfer(input bit b, input logic [31:0] addr, input bit r, input logic [31:0] d,
                      input logic [3:0] e, output logic [31:0] rd, output int l);
    repeat (2) @(negedge clk);
    abus = addr; rnw = r; dbus = d; be = e;
    if (b) sel_b = 1'b1; else sel_a = 1'b1;
    l = 0; rd = 32'hx;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (b ? ack_b : ack_a) begin
        l = c; rd = b ? sl_dbus_b : sl_dbus_a;
        break;
      end
    end
    @(negedge clk);
    sel_a = 1'b0; sel_b = 1'b0;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("rst_uda", uda_a, {4{INIT_A}});
    check("rst_dirty", dirty_a, 1'b0);
    check("rst_ack", ack_a, 1'b0);
    check("rst_dbus", sl_dbus_a, 32'h0);
    check("rst_upd", upd_a, 1'b0);
    xfer(0, BASE + 4, 0, 32'hDEADBEEF, 4'b1111, rdata, lat);
    check("wr1_latency", lat, 1);
    @(posedge clk); #1;
    check("wr1_out_unchanged", uda_a, {4{INIT_A}});
    check("wr1_dirty", dirty_a, 1'b1);
    check("dbus_idle_zero", sl_dbus_a, 32'h0);
    xfer(0, BASE + 16, 1, 0, 4'b1111, rdata, lat);
    check("ctrl_rd_lat", lat, 1);
    check("ctrl_rd_dirty", rdata, 32'h00000001);
    xfer(0, BASE + 4, 1, 0, 4'b1111, rdata, lat);
`ifdef OPB_REGBANK_READBACK_EN
    check("rd_shadow1", rdata, 32'hDEADBEEF);
`else
    check("rd_shadow1", rdata, 32'h0);
`endif
    xfer(0, BASE, 0, 32'hAABBCCDD, 4'b1111, rdata, lat);
    xfer(0, BASE, 0, 32'h12345678, 4'b0011, rdata, lat);
    check("be_wr_lat", lat, 1);
    xfer(0, BASE + 16, 0, 32'h00000001, 4'b1111, rdata, lat);
    check("commit_out_before", uda_a, {4{INIT_A}});
    @(posedge clk); #1;
    check("commit_upd", upd_a, 1'b1);
    check("commit_uda", uda_a, {INIT_A, INIT_A, 32'hDEADBEEF, 32'hAABB5678});
    check("commit_dirty", dirty_a, 1'b0);
    @(posedge clk); #1;
    check("commit_upd_once", upd_a, 1'b0);
    xfer(0, BASE + 8, 0, 32'h5, 4'b1111, rdata, lat);
    xfer(0, BASE + 16, 0, 32'h00000002, 4'b1111, rdata, lat);
    acks = 0;
    repeat (3) begin
      @(posedge clk); #1;
      acks += int'(upd_a);
    end
    check("revert_no_upd", acks, 0);
    check("revert_uda", uda_a, {INIT_A, INIT_A, 32'hDEADBEEF, 32'hAABB5678});
    check("revert_dirty", dirty_a, 1'b0);
    xfer(0, BASE + 8, 1, 0, 4'b1111, rdata, lat);
`ifdef OPB_REGBANK_READBACK_EN
    check("revert_rd2", rdata, INIT_A);
    xfer(0, BASE + 20, 1, 0, 4'b1111, rdata, lat);
    check("commit_cnt", rdata, 32'h1);
`else
    check("revert_rd2", rdata, 32'h0);
`endif
    xfer(0, BASE + 16, 0, 32'h00000003, 4'b1111, rdata, lat);
    @(posedge clk); #1;
    check("both_bits_commit_upd", upd_a, 1'b1);
    xfer(0, BASE + 32'h40, 1, 0, 4'b1111, rdata, lat);
    check("unmapped_lat", lat, 1);
    check("unmapped_rd", rdata, 32'h0);
    xfer(0, BASE + 32'h100, 1, 0, 4'b1111, rdata, lat);
    check("out_of_range_noack", lat, 0);
    repeat (2) @(negedge clk);
    abus = BASE + 12; rnw = 0; dbus = 32'h11; be = 4'b1111; sel_a = 1'b1;
    acks = 0;
    repeat (6) begin
      @(posedge clk); #1;
      acks += int'(ack_a);
    end
    @(negedge clk) sel_a = 1'b0;
    check("held_select_one_ack", acks, 1);
    check("held_dirty", dirty_a, 1'b1);
    repeat (2) @(negedge clk);
    abus = BASE + 16; rnw = 0; dbus = 32'h1; be = 4'b1111; sel_a = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ack_acked", ack_a, 1'b1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ack_noack", ack_a, 1'b0);
    check("rst_in_ack_upd", upd_a, 1'b0);
    check("rst_in_ack_uda", uda_a, {4{INIT_A}});
    check("rst_in_ack_dirty", dirty_a, 1'b0);
    @(negedge clk);
    rst = 1'b0; sel_a = 1'b0;
    @(posedge clk); #1;
    check("post_rst_upd", upd_a, 1'b0);
    xfer(0, BASE + 16, 1, 0, 4'b1111, rdata, lat);
    check("post_rst_lat", lat, 1);
    check("post_rst_ctrl", rdata, 32'h0);
    xfer(1, BASE + 12, 0, 32'h7, 4'b1111, rdata, lat);
    check("auto_lat", lat, 1);
    @(posedge clk); #1;
    check("auto_uda", uda_b, {32'h7, 96'h0});
    check("auto_upd", upd_b, 1'b1);
    check("auto_dirty", dirty_b, 1'b0);
    xfer(1, BASE + 16, 1, 0, 4'b1111, rdata, lat);
    check("auto_ctrl", rdata, 32'h00000002);
    check("a_untouched_by_b", uda_a, {4{INIT_A}});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
